// File: rtl/tt_um_alu_seq_kdcastillor.sv
// Sequential 8-bit ALU tile: operands/opcode loaded over ui_in by a synchronized strobe,
// arithmetic ops run through a single bit-serial full adder, logic/shift ops take one cycle.
module tt_um_alu_seq_kdcastillor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  localparam logic [1:0] SEL_A  = 2'b00;
  localparam logic [1:0] SEL_B  = 2'b01;
  localparam logic [1:0] SEL_OP = 2'b10;
  localparam logic [1:0] SEL_GO = 2'b11;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ADC = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rc_q, rc_d;
  logic             carry_q, carry_d, zero_q, zero_d;
  logic             busy_q, busy_d, valid_q, valid_d;

  logic             strobe;
  logic [1:0]       sel;
  logic             is_arith;
  logic             b_bit, sum_bit, cout_bit;
  logic [WIDTH-1:0] logic_res;
  logic             logic_carry;
  logic             unused_ok;

  assign strobe    = s2_q & ~s3_q;
  assign sel       = uio_in[2:1];
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);
  assign unused_ok = &{1'b0, uio_in[7:3]};

  // One full-adder cell; SUB feeds the inverted B bit with carry-in preset to 1.
  always_comb begin
    b_bit    = (op_q == OP_SUB) ? ~b_q[cnt_q] : b_q[cnt_q];
    sum_bit  = a_q[cnt_q] ^ b_bit ^ rc_q;
    cout_bit = (a_q[cnt_q] & b_bit) | (a_q[cnt_q] & rc_q) | (b_bit & rc_q);
  end

  always_comb begin
    logic_res   = '0;
    logic_carry = 1'b0;
    case (op_q)
      OP_AND: logic_res = a_q & b_q;
      OP_OR:  logic_res = a_q | b_q;
      OP_XOR: logic_res = a_q ^ b_q;
      OP_SHL: begin
        logic_res   = {a_q[WIDTH-2:0], 1'b0};
        logic_carry = a_q[WIDTH-1];
      end
      OP_SHR: begin
        logic_res   = {1'b0, a_q[WIDTH-1:1]};
        logic_carry = a_q[0];
      end
      default: begin
        logic_res   = '0;
        logic_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    s1_d    = uio_in[0];
    s2_d    = s1_q;
    s3_d    = s2_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    valid_d = valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (strobe) begin
          case (sel)
            SEL_A: begin
              a_d     = ui_in;
              valid_d = 1'b0;
              state_d = IDLE;
            end
            SEL_B: begin
              b_d     = ui_in;
              valid_d = 1'b0;
              state_d = IDLE;
            end
            SEL_OP: begin
              op_d    = ui_in[2:0];
              valid_d = 1'b0;
              state_d = IDLE;
            end
            SEL_GO: begin
              state_d = EXEC;
              busy_d  = 1'b1;
              valid_d = 1'b0;
              cnt_d   = '0;
              acc_d   = '0;
              // ADC chains the carry left by the previous completed operation.
              rc_d    = (op_q == OP_SUB) ? 1'b1 :
                        (op_q == OP_ADC) ? carry_q : 1'b0;
            end
            default: state_d = state_q;
          endcase
        end
      end
      EXEC: begin
        if (is_arith) begin
          acc_d = {sum_bit, acc_q[WIDTH-1:1]};
          rc_d  = cout_bit;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_d   = acc_d;
            carry_d = cout_bit;
            zero_d  = (acc_d == '0);
            busy_d  = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          res_d   = logic_res;
          carry_d = logic_carry;
          zero_d  = (logic_res == '0);
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rc_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {zero_q, carry_q, valid_q, busy_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_alu_seq_kdcastillor.sv
// Bench for the sequential ALU tile: directed table, randomized ops against an arithmetic
// reference model, and hand-built sequences for pause, abort and ignored strobes.
module tb_tt_um_alu_seq_kdcastillor;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  int   checks = 0;
  int   errors = 0;
  logic model_cf = 1'b0;

  always #5 clk = ~clk;

  tt_um_alu_seq_kdcastillor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ld held for edges 0..2, then low for two edges before the next strobe.
  task automatic load(input logic [1:0] sel, input logic [7:0] data);
    ui_in  = data;
    uio_in = {5'b0, sel, 1'b1};
    repeat (3) step();
    uio_in[0] = 1'b0;
    repeat (2) step();
  endtask

  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                 input logic cin, output logic [7:0] r, output logic c);
    logic [8:0] wide;
    wide = 9'd0;
    c    = 1'b0;
    case (op)
      3'd0: wide = a + b;
      3'd1: wide = a + (9'd255 - b) + 9'd1;
      3'd7: wide = a + b + cin;
      3'd2: wide = {1'b0, a & b};
      3'd3: wide = {1'b0, a | b};
      3'd4: wide = {1'b0, a ^ b};
      3'd5: wide = {a[7], a[6:0], 1'b0};
      default: wide = {a[0], 1'b0, a[7:1]};
    endcase
    r = wide[7:0];
    c = wide[8];
  endfunction

  task automatic run_go(input string tag, input logic [7:0] er, input logic ec, input logic ez,
                        input int elat, input int pause_at, input bit inj,
                        input logic [1:0] inj_sel, input logic [7:0] inj_data);
    int n;
    uio_in = {5'b0, 2'b11, 1'b1};
    repeat (3) step();
    check({tag, " busy/valid at start"}, {30'b0, uio_out[5:4]}, 32'h1);
    uio_in[0] = 1'b0;
    n = 0;
    while (uio_out[5] !== 1'b1 && n < 60) begin
      ena = !(pause_at >= 0 && n >= pause_at && n < pause_at + 5);
      if (inj && n >= 2 && n <= 4) begin
        ui_in  = inj_data;
        uio_in = {5'b0, inj_sel, 1'b1};
      end else begin
        uio_in[0] = 1'b0;
      end
      step();
      n++;
    end
    ena       = 1'b1;
    uio_in[0] = 1'b0;
    check({tag, " latency"}, n, elat);
    check({tag, " result"}, {24'b0, uo_out}, {24'b0, er});
    check({tag, " flags"}, {24'b0, uio_out}, {24'b0, ez, ec, 1'b1, 1'b0, 4'b0});
    $display("%s: res=%02h c=%0b z=%0b lat=%0d (exp %02h c=%0b z=%0b lat=%0d)",
             tag, uo_out, uio_out[6], uio_out[7], n, er, ec, ez, elat);
    step();
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] er, input logic ec,
                       input logic ez, input int elat, input int pause_at);
    load(2'b00, a);
    load(2'b01, b);
    load(2'b10, {5'b0, op});
    check({tag, " valid cleared by load"}, {31'b0, uio_out[5]}, 32'h0);
    run_go(tag, er, ec, ez, elat, pause_at, 1'b0, 2'b00, 8'h00);
  endtask

  vec_t vecs[11];

  initial begin
    logic [7:0] a, b, r;
    logic [2:0] op;
    logic       c;

    vecs[0]  = '{8'hC8, 8'h64, 3'd0, 8'h2C, 1'b1, 1'b0, 8};
    vecs[1]  = '{8'h05, 8'h07, 3'd1, 8'hFE, 1'b0, 1'b0, 8};
    vecs[2]  = '{8'h07, 8'h07, 3'd1, 8'h00, 1'b1, 1'b1, 8};
    vecs[3]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 8};
    vecs[4]  = '{8'h10, 8'h20, 3'd7, 8'h31, 1'b0, 1'b0, 8};
    vecs[5]  = '{8'hAA, 8'hFF, 3'd4, 8'h55, 1'b0, 1'b0, 1};
    vecs[6]  = '{8'h01, 8'h00, 3'd6, 8'h00, 1'b1, 1'b1, 1};
    vecs[7]  = '{8'h81, 8'h00, 3'd5, 8'h02, 1'b1, 1'b0, 1};
    vecs[8]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1};
    vecs[9]  = '{8'hF0, 8'h0F, 3'd3, 8'hFF, 1'b0, 1'b0, 1};
    vecs[10] = '{8'hFF, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 8};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset, with a strobe for A issued while reset is still asserted.
    repeat (2) step();
    check("reset uo_out", {24'b0, uo_out}, 32'h0);
    check("reset uio_out", {24'b0, uio_out}, 32'h0);
    check("reset uio_oe", {24'b0, uio_oe}, 32'hF0);
    load(2'b00, 8'h55);
    check("uio_oe during reset", {24'b0, uio_oe}, 32'hF0);
    rst_n = 1'b1;
    step();
    run_go("reset no-load", 8'h00, 1'b0, 1'b1, 8, -1, 1'b0, 2'b00, 8'h00);

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
            vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].lat, -1);
      model_cf = vecs[i].c;
    end

    // ena low for 5 cycles mid-EXEC stretches latency by exactly 5.
    do_op("ena pause", 8'hC8, 8'h64, 3'd0, 8'h2C, 1'b1, 1'b0, 13, 3);

    // A write during EXEC is ignored; a second GO confirms A kept its value.
    load(2'b00, 8'h12);
    load(2'b01, 8'h34);
    load(2'b10, 8'h00);
    run_go("A write in EXEC", 8'h46, 1'b0, 1'b0, 8, -1, 1'b1, 2'b00, 8'hFF);
    run_go("rerun after write", 8'h46, 1'b0, 1'b0, 8, -1, 1'b0, 2'b00, 8'h00);

    // GO during EXEC must not restart the operation.
    load(2'b00, 8'hF0);
    load(2'b01, 8'h20);
    run_go("GO in EXEC", 8'h10, 1'b1, 1'b0, 8, -1, 1'b1, 2'b11, 8'h00);

    // Reset mid-EXEC aborts and clears everything, carry included.
    uio_in = {5'b0, 2'b11, 1'b1};
    repeat (3) step();
    uio_in[0] = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("abort uo_out", {24'b0, uo_out}, 32'h0);
    check("abort uio_out", {24'b0, uio_out}, 32'h0);
    rst_n = 1'b1;
    step();
    model_cf = 1'b0;
    do_op("after abort ADC", 8'h03, 8'h04, 3'd7, 8'h07, 1'b0, 1'b0, 8, -1);

    // Randomized ops against the reference model, carry chained across ops.
    for (int i = 0; i < 30; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      ref_op(a, b, op, model_cf, r, c);
      do_op($sformatf("rand%0d op%0d %02h,%02h", i, op, a, b), a, b, op, r, c, (r == 8'h00),
            (op == 3'd0 || op == 3'd1 || op == 3'd7) ? 8 : 1, -1);
      model_cf = c;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
